// File: rtl/exe_pkg.sv
// Shared definitions for the execute stage.
// Contents: unit select, B-operand source and FSM state enums, the NZVC flag
// struct and the ALU control encoding used by the decode stage.
package exe_pkg;

  typedef enum logic [1:0] {
    UNIT_ALU = 2'd0,
    UNIT_LSR = 2'd1,
    UNIT_LSL = 2'd2,
    UNIT_MUL = 2'd3
  } unit_sel_e;

  typedef enum logic [1:0] {
    SRC_RD2   = 2'd0,
    SRC_IMM9  = 2'd1,
    SRC_IMM12 = 2'd2,
    SRC_ZERO  = 2'd3
  } alu_src_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } ex_state_e;

  typedef struct packed {
    logic n;
    logic z;
    logic v;
    logic c;
  } flags_t;

  // ALU control encoding
  localparam logic [2:0] ALU_AND    = 3'b000;
  localparam logic [2:0] ALU_ORR    = 3'b001;
  localparam logic [2:0] ALU_ADD    = 3'b010;
  localparam logic [2:0] ALU_EOR    = 3'b011;
  localparam logic [2:0] ALU_PASS_B = 3'b100;
  localparam logic [2:0] ALU_NOR    = 3'b101;
  localparam logic [2:0] ALU_SUB    = 3'b110;
  localparam logic [2:0] ALU_PASS_A = 3'b111;

endpackage

// File: rtl/execute_stage_mc_iter_multiplier.sv
// Iterative shift-add multiplier, one multiplier bit per cycle.
// Ports: start latches the operands and begins DATA_W iterations; busy is high
// while iterating; done is high during the final iteration (product then shows
// the combinational final sum) and stays high while the finished product is
// held; abort clears busy/done (used both for kill and for "product taken").
module iter_multiplier #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] multiplicand,
  input  logic [DATA_W-1:0] multiplier,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] product
);
  localparam int CNT_W = $clog2(DATA_W);

  logic [DATA_W-1:0] mcand_reg, mplier_reg, acc_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              busy_reg, done_reg;
  logic              last_step;
  logic [DATA_W-1:0] addend, acc_sum;

  assign last_step = busy_reg && (cnt_reg == CNT_W'(DATA_W - 1));
  assign addend    = mplier_reg[0] ? mcand_reg : '0;
  assign acc_sum   = acc_reg + addend;
  // Exposing the final sum during the last iteration lets the caller load it
  // on the same edge, saving a cycle of latency.
  assign done      = last_step || done_reg;
  assign product   = done_reg ? acc_reg : acc_sum;
  assign busy      = busy_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else if (abort) begin
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
    end else if (start) begin
      mcand_reg  <= multiplicand;
      mplier_reg <= multiplier;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      busy_reg   <= 1'b1;
      done_reg   <= 1'b0;
    end else if (busy_reg) begin
      acc_reg    <= acc_sum;
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      cnt_reg    <= cnt_reg + 1'b1;
      if (last_step) begin
        busy_reg <= 1'b0;
        done_reg <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/execute_stage_mc.sv
// Handshaked execute stage: ALU, LSR, LSL and iterative MUL feeding a
// registered EX/MEM output, plus the NZVC flag register.
// Ports: in_valid/in_ready accept an op from decode; out_valid/out_ready hand
// the registered result (and rd_data2/wr_data/rd/control passthroughs) to the
// memory stage; negative_ex/overflow_ex are same-cycle ALU flags for B.cond;
// *_flag are the registered NZVC flags; busy marks multiplier iteration;
// flush kills the in-flight op, the held output and any same-cycle fire.
module execute_stage_mc
  import exe_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int SHAMT_W = $clog2(DATA_W)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  rd_data1,
  input  logic [DATA_W-1:0]  rd_data2,
  input  logic [DATA_W-1:0]  imm9,
  input  logic [DATA_W-1:0]  imm12,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic [1:0]         alu_src,
  input  logic [2:0]         alu_op,
  input  logic [1:0]         unit_sel,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               set_flag,
  input  logic               mem_write,
  input  logic               mem_to_reg,
  input  logic               reg_write,
  input  logic [4:0]         rd,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  result,
  output logic [DATA_W-1:0]  rd_data2_q,
  output logic [DATA_W-1:0]  wr_data_q,
  output logic [4:0]         rd_q,
  output logic               mem_write_q,
  output logic               mem_to_reg_q,
  output logic               reg_write_q,
  output logic               negative_ex,
  output logic               overflow_ex,
  output logic               negative_flag,
  output logic               zero_flag,
  output logic               overflow_flag,
  output logic               carry_flag,
  output logic               busy
);
  ex_state_e         state_reg, state_next;
  logic [DATA_W-1:0] b_operand, b_eff, alu_result, single_result;
  logic [DATA_W:0]   sum;
  logic              alu_v, alu_c, is_sub;
  flags_t            single_flags, mul_flags, flag_reg;
  logic              in_fire, out_free;
  logic              load_single, load_mul, mul_start, mul_abort;
  logic              mul_busy, mul_done;
  logic [DATA_W-1:0] mul_product;
  // Controls captured at MUL start; decode moves on while we iterate.
  logic [DATA_W-1:0] mul_rd2_reg, mul_wr_data_reg;
  logic [4:0]        mul_rd_reg;
  logic [3:0]        mul_ctrl_reg; // {set_flag, mem_write, mem_to_reg, reg_write}
  logic              out_valid_reg;

  always_comb begin
    case (alu_src)
      SRC_RD2:   b_operand = rd_data2;
      SRC_IMM9:  b_operand = imm9;
      SRC_IMM12: b_operand = imm12;
      default:   b_operand = '0;
    endcase
  end

  // Subtraction as a + ~b + 1 so carry means "no borrow".
  always_comb begin
    is_sub     = (alu_op == ALU_SUB);
    b_eff      = is_sub ? ~b_operand : b_operand;
    sum        = {1'b0, rd_data1} + {1'b0, b_eff} + {{DATA_W{1'b0}}, is_sub};
    alu_result = '0;
    alu_v      = 1'b0;
    alu_c      = 1'b0;
    case (alu_op)
      ALU_AND:    alu_result = rd_data1 & b_operand;
      ALU_ORR:    alu_result = rd_data1 | b_operand;
      ALU_EOR:    alu_result = rd_data1 ^ b_operand;
      ALU_NOR:    alu_result = ~(rd_data1 | b_operand);
      ALU_PASS_B: alu_result = b_operand;
      ALU_PASS_A: alu_result = rd_data1;
      default: begin // ADD, SUB
        alu_result = sum[DATA_W-1:0];
        alu_c      = sum[DATA_W];
        alu_v      = (rd_data1[DATA_W-1] == b_eff[DATA_W-1]) &&
                     (sum[DATA_W-1] != rd_data1[DATA_W-1]);
      end
    endcase
  end

  assign negative_ex = alu_result[DATA_W-1];
  assign overflow_ex = alu_v;

  always_comb begin
    case (unit_sel)
      UNIT_LSR: single_result = rd_data1 >> shamt;
      UNIT_LSL: single_result = rd_data1 << shamt;
      default:  single_result = alu_result;
    endcase
    single_flags.n = single_result[DATA_W-1];
    single_flags.z = (single_result == '0);
    single_flags.v = (unit_sel == UNIT_ALU) ? alu_v : 1'b0;
    single_flags.c = (unit_sel == UNIT_ALU) ? alu_c : 1'b0;
    mul_flags.n    = mul_product[DATA_W-1];
    mul_flags.z    = (mul_product == '0);
    mul_flags.v    = 1'b0;
    mul_flags.c    = 1'b0;
  end

  assign out_free = !out_valid_reg || out_ready;
  assign in_ready = (state_reg == ST_IDLE) && out_free;
  assign in_fire  = in_valid && in_ready;

  always_comb begin
    state_next  = state_reg;
    load_single = 1'b0;
    load_mul    = 1'b0;
    mul_start   = 1'b0;
    mul_abort   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (in_fire && !flush) begin
          if (unit_sel == UNIT_MUL) begin
            mul_start  = 1'b1;
            state_next = ST_MUL;
          end else begin
            load_single = 1'b1;
          end
        end
      end
      default: begin // ST_MUL
        if (flush) begin
          mul_abort  = 1'b1;
          state_next = ST_IDLE;
        end else if (mul_done && out_free) begin
          // Product taken: abort clears the multiplier's held-done state.
          load_mul   = 1'b1;
          mul_abort  = 1'b1;
          state_next = ST_IDLE;
        end
      end
    endcase
  end

  iter_multiplier #(.DATA_W(DATA_W)) u_mul (
    .clk          (clk),
    .reset        (reset),
    .start        (mul_start),
    .abort        (mul_abort),
    .multiplicand (rd_data1),
    .multiplier   (b_operand),
    .busy         (mul_busy),
    .done         (mul_done),
    .product      (mul_product)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      mul_rd2_reg     <= '0;
      mul_wr_data_reg <= '0;
      mul_rd_reg      <= '0;
      mul_ctrl_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (mul_start) begin
        mul_rd2_reg     <= rd_data2;
        mul_wr_data_reg <= wr_data;
        mul_rd_reg      <= rd;
        mul_ctrl_reg    <= {set_flag, mem_write, mem_to_reg, reg_write};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_reg <= 1'b0;
      result        <= '0;
      rd_data2_q    <= '0;
      wr_data_q     <= '0;
      rd_q          <= '0;
      mem_write_q   <= 1'b0;
      mem_to_reg_q  <= 1'b0;
      reg_write_q   <= 1'b0;
      flag_reg      <= '0;
    end else if (flush) begin
      out_valid_reg <= 1'b0;
    end else if (load_single) begin
      out_valid_reg <= 1'b1;
      result        <= single_result;
      rd_data2_q    <= rd_data2;
      wr_data_q     <= wr_data;
      rd_q          <= rd;
      mem_write_q   <= mem_write;
      mem_to_reg_q  <= mem_to_reg;
      reg_write_q   <= reg_write;
      if (set_flag) flag_reg <= single_flags;
    end else if (load_mul) begin
      out_valid_reg <= 1'b1;
      result        <= mul_product;
      rd_data2_q    <= mul_rd2_reg;
      wr_data_q     <= mul_wr_data_reg;
      rd_q          <= mul_rd_reg;
      {mem_write_q, mem_to_reg_q, reg_write_q} <= mul_ctrl_reg[2:0];
      if (mul_ctrl_reg[3]) flag_reg <= mul_flags;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid     = out_valid_reg;
  assign busy          = mul_busy;
  assign negative_flag = flag_reg.n;
  assign zero_flag     = flag_reg.z;
  assign overflow_flag = flag_reg.v;
  assign carry_flag    = flag_reg.c;
endmodule
